// File: rtl/mac_cluster_stream.sv
// mac_cluster_stream
//   LANES independent MAC_MIN_WIDTH x MAC_MIN_WIDTH multiply(-accumulate) lanes
//   behind valid/ready handshakes. A config handshake loads the mode, the vector
//   length and the per-lane initial accumulators. In MAC mode each lane sums
//   len products, emits one result word and re-arms to its initial value. In
//   MUL mode every accepted beat produces one result word of plain products.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   cfg_valid/cfg_ready    config handshake; cfg_mode[0] 1=MAC 0=MUL,
//                          cfg_mode[1] 1=signed 0=unsigned
//   cfg_len                products per result in MAC mode (0 behaves as 1)
//   cfg_init               initial accumulator per lane, lane 0 in LSBs
//   in_valid/in_ready      operand beat handshake
//   in_a, in_b             per-lane operands, lane 0 in LSBs
//   out_valid/out_ready    result handshake
//   out_data               per-lane results, lane 0 in LSBs

module mac_cluster_stream #(
    parameter int LANES         = 4,
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_ACC_WIDTH = 32,
    parameter int LEN_WIDTH     = 8,
    parameter bit SATURATE      = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [1:0]                       cfg_mode,
    input  logic [LEN_WIDTH-1:0]             cfg_len,
    input  logic [LANES*MAC_ACC_WIDTH-1:0]   cfg_init,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*MAC_MIN_WIDTH-1:0]   in_a,
    input  logic [LANES*MAC_MIN_WIDTH-1:0]   in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*MAC_ACC_WIDTH-1:0]   out_data
);

    localparam int MW = MAC_MIN_WIDTH;
    localparam int AW = MAC_ACC_WIDTH;
    localparam int PW = 2 * MAC_MIN_WIDTH;

    localparam logic [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               mode_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [LEN_WIDTH-1:0]     count_q;
    logic [LANES*AW-1:0]      init_q;
    logic [LANES*AW-1:0]      acc_q;
    logic                     out_valid_q;
    logic [LANES*AW-1:0]      out_data_q;

    logic                     mac_mode;
    logic                     sgn;
    logic                     cfg_fire;
    logic                     in_fire;
    logic [LEN_WIDTH-1:0]     len_last;
    logic [LANES*AW-1:0]      prod_ext;
    logic [LANES*AW-1:0]      sum;

    assign mac_mode = mode_q[0];
    assign sgn      = mode_q[1];

    // Index of the final beat of a vector; a length of zero behaves as one.
    assign len_last = (len_q == '0) ? '0 : len_q - 1'b1;

    // A config word is only taken between vectors with no result outstanding,
    // and it takes priority over an operand beat in the same cycle.
    assign cfg_ready = (count_q == '0) && !out_valid_q;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready) && !cfg_fire;
    assign in_fire   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [MW-1:0]        a, b;
        logic signed [PW-1:0] p_s;
        logic [PW-1:0]        p_u;
        logic [AW-1:0]        p_ext;
        logic [AW-1:0]        acc;
        logic [AW:0]          sum_wide;
        logic                 acc_x, p_x;
        logic [AW-1:0]        sum_lane;

        assign a   = in_a[l*MW +: MW];
        assign b   = in_b[l*MW +: MW];
        assign acc = acc_q[l*AW +: AW];

        // Operands are widened to the full product width first so the
        // multiply keeps every product bit.
        assign p_s = $signed({{MW{a[MW-1]}}, a}) * $signed({{MW{b[MW-1]}}, b});
        assign p_u = {{MW{1'b0}}, a} * {{MW{1'b0}}, b};

        assign p_ext = sgn ? AW'(p_s) : AW'(p_u);

        // One guard bit: a sign copy in signed mode, zero in unsigned mode,
        // so the top bit of sum_wide exposes overflow either way.
        assign acc_x    = sgn & acc[AW-1];
        assign p_x      = sgn & p_ext[AW-1];
        assign sum_wide = {acc_x, acc} + {p_x, p_ext};

        // NOTE: every signal written in always_comb gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        always_comb begin
            sum_lane = sum_wide[AW-1:0];
            if (SATURATE) begin
                if (sgn && (sum_wide[AW] != sum_wide[AW-1])) begin
                    sum_lane = sum_wide[AW] ? SMIN : SMAX;
                end else if (!sgn && sum_wide[AW]) begin
                    sum_lane = '1;
                end
            end
        end

        assign prod_ext[l*AW +: AW] = p_ext;
        assign sum[l*AW +: AW]      = sum_lane;
    end

    always_comb begin
        state_d = state_q;
        if (cfg_fire) begin
            state_d = RUN;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the design holds only control and datapath registers (no
        // memories), so all of them are cleared by reset; this also drops any
        // partial sum and pending result.
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            len_q       <= '0;
            init_q      <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;

            // A completing beat below overrides this, giving back-to-back
            // results with no bubble.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (cfg_fire) begin
                mode_q  <= cfg_mode;
                len_q   <= cfg_len;
                init_q  <= cfg_init;
                acc_q   <= cfg_init;
                count_q <= '0;
            end else if (in_fire) begin
                if (!mac_mode) begin
                    out_data_q  <= prod_ext;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    count_q     <= '0;
                end else if (count_q == len_last) begin
                    out_data_q  <= sum;
                    out_valid_q <= 1'b1;
                    acc_q       <= init_q;
                    count_q     <= '0;
                end else begin
                    acc_q   <= sum;
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_cluster_stream.sv
// tb_mac_cluster_stream
//   Drives a wrapping (SATURATE=0) and a clamping (SATURATE=1) instance from the
//   same stimulus. A transaction-level model built on integer arithmetic tracks
//   the expected handshakes and result words of both. Directed vectors come from
//   a table; a few hand-written sequences cover back-pressure, reconfiguration
//   and reset; a randomized phase closes out the run.

module tb_mac_cluster_stream;

    localparam int L  = 4;
    localparam int MW = 8;
    localparam int AW = 32;
    localparam int LW = 8;

    localparam longint S_MIN = -64'sd2147483648;
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint U_MAX = 64'sd4294967295;

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic [1:0]        cfg_mode;
    logic [LW-1:0]     cfg_len;
    logic [L*AW-1:0]   cfg_init;
    logic              in_valid;
    logic [L*MW-1:0]   in_a;
    logic [L*MW-1:0]   in_b;
    logic              out_ready;

    logic              cfg_ready_w, in_ready_w, out_valid_w;
    logic [L*AW-1:0]   out_data_w;
    logic              cfg_ready_s, in_ready_s, out_valid_s;
    logic [L*AW-1:0]   out_data_s;

    mac_cluster_stream #(
        .LANES(L), .MAC_MIN_WIDTH(MW), .MAC_ACC_WIDTH(AW), .LEN_WIDTH(LW), .SATURATE(1'b0)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_w), .cfg_mode(cfg_mode),
        .cfg_len(cfg_len), .cfg_init(cfg_init),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w)
    );

    mac_cluster_stream #(
        .LANES(L), .MAC_MIN_WIDTH(MW), .MAC_ACC_WIDTH(AW), .LEN_WIDTH(LW), .SATURATE(1'b1)
    ) u_sat (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_s), .cfg_mode(cfg_mode),
        .cfg_len(cfg_len), .cfg_init(cfg_init),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_results = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: integer arithmetic on the lane values
    // ------------------------------------------------------------------
    bit                     m_configured;
    bit                     m_pending;
    logic [1:0]             m_mode;
    int                     m_len_eff;
    int                     m_count;
    logic [L-1:0][AW-1:0]   m_init, m_acc_w, m_acc_s, m_out_w, m_out_s;
    bit                     g_cfg_fire, g_in_fire;

    task automatic model_reset();
        m_configured = 1'b0;
        m_pending    = 1'b0;
        m_mode       = '0;
        m_len_eff    = 1;
        m_count      = 0;
        m_init       = '0;
        m_acc_w      = '0;
        m_acc_s      = '0;
        m_out_w      = '0;
        m_out_s      = '0;
    endtask

    function automatic longint to_num(input logic [AW-1:0] v, input bit sgn);
        if (sgn) return longint'($signed(v));
        return longint'(v);
    endfunction

    function automatic logic [AW-1:0] clamp(input longint x, input bit sgn);
        longint y;
        y = x;
        if (sgn) begin
            if (x > S_MAX) y = S_MAX;
            if (x < S_MIN) y = S_MIN;
        end else begin
            if (x > U_MAX) y = U_MAX;
            if (x < 0)     y = 0;
        end
        return y[AW-1:0];
    endfunction

    // Samples the DUTs 1 time unit after the inputs were set (mid-low phase),
    // compares against the model, advances the model across the coming rising
    // edge and returns at the next falling edge.
    task automatic tick();
        bit exp_cfg_ready, exp_in_ready, cfg_fire, in_fire;
        #1;
        exp_cfg_ready = (m_count == 0) && !m_pending;
        exp_in_ready  = m_configured && (!m_pending || out_ready) && !(cfg_valid && exp_cfg_ready);
        check("cfg_ready wrap", cfg_ready_w, exp_cfg_ready);
        check("cfg_ready sat",  cfg_ready_s, exp_cfg_ready);
        check("in_ready wrap",  in_ready_w,  exp_in_ready);
        check("in_ready sat",   in_ready_s,  exp_in_ready);
        check("out_valid wrap", out_valid_w, m_pending);
        check("out_valid sat",  out_valid_s, m_pending);
        if (m_pending) begin
            check("out_data wrap", out_data_w, m_out_w);
            check("out_data sat",  out_data_s, m_out_s);
        end
        cfg_fire   = cfg_valid && exp_cfg_ready;
        in_fire    = in_valid && exp_in_ready;
        g_cfg_fire = cfg_fire;
        g_in_fire  = in_fire;
        if (m_pending && out_ready) begin
            m_pending = 1'b0;
            n_results++;
        end
        if (cfg_fire) begin
            m_configured = 1'b1;
            m_mode       = cfg_mode;
            m_len_eff    = (cfg_len == 0) ? 1 : int'(cfg_len);
            m_init       = cfg_init;
            m_acc_w      = cfg_init;
            m_acc_s      = cfg_init;
            m_count      = 0;
        end else if (in_fire) begin
            bit sgn;
            bit last;
            sgn  = m_mode[1];
            last = !m_mode[0] || (m_count == m_len_eff - 1);
            for (int l = 0; l < L; l++) begin
                logic [MW-1:0] a, b;
                longint p, sw, ss;
                a = in_a[l*MW +: MW];
                b = in_b[l*MW +: MW];
                if (sgn) p = longint'($signed(a)) * longint'($signed(b));
                else     p = longint'(a) * longint'(b);
                if (!m_mode[0]) begin
                    m_out_w[l] = p[AW-1:0];
                    m_out_s[l] = p[AW-1:0];
                end else begin
                    sw = to_num(m_acc_w[l], sgn) + p;
                    ss = to_num(m_acc_s[l], sgn) + p;
                    if (last) begin
                        m_out_w[l] = sw[AW-1:0];
                        m_out_s[l] = clamp(ss, sgn);
                    end else begin
                        m_acc_w[l] = sw[AW-1:0];
                        m_acc_s[l] = clamp(ss, sgn);
                    end
                end
            end
            if (last) begin
                m_pending = 1'b1;
                m_count   = 0;
                m_acc_w   = m_init;
                m_acc_s   = m_init;
            end else begin
                m_count++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_cfg(input logic [1:0] mode, input logic [LW-1:0] len, input logic [L*AW-1:0] init);
        bit fired;
        fired     = 1'b0;
        cfg_mode  = mode;
        cfg_len   = len;
        cfg_init  = init;
        cfg_valid = 1'b1;
        for (int t = 0; t < 20 && !fired; t++) begin
            tick();
            fired = g_cfg_fire;
        end
        cfg_valid = 1'b0;
        check("cfg handshake within bound", fired, 1'b1);
    endtask

    task automatic do_beat(input logic [L*MW-1:0] a, input logic [L*MW-1:0] b);
        bit fired;
        fired    = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !fired; t++) begin
            tick();
            fired = g_in_fire;
        end
        in_valid = 1'b0;
        check("beat handshake within bound", fired, 1'b1);
    endtask

    function automatic logic [L*MW-1:0] lane_op(input int lane, input logic [MW-1:0] v);
        logic [L*MW-1:0] r;
        r = '0;
        r[lane*MW +: MW] = v;
        return r;
    endfunction

    function automatic logic [L*AW-1:0] lane_word(input int lane, input logic [AW-1:0] v);
        logic [L*AW-1:0] r;
        r = '0;
        r[lane*AW +: AW] = v;
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 8'h7F;
            1:       return 8'h80;
            2:       return 8'hFF;
            default: return MW'($urandom);
        endcase
    endfunction

    function automatic logic [AW-1:0] rand_init();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFFFF00 | AW'($urandom_range(0, 255));
            1:       return 32'h80000000 | AW'($urandom_range(0, 255));
            2:       return 32'hFFFFFF00 | AW'($urandom_range(0, 255));
            default: return AW'($urandom);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]          mode;
        logic [LW-1:0]       len;
        int                  lane;
        logic [AW-1:0]       init;
        int                  nb;
        logic [2:0][MW-1:0]  a;
        logic [2:0][MW-1:0]  b;
        logic [AW-1:0]       exp_w;
        logic [AW-1:0]       exp_s;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] mode, input logic [LW-1:0] len, input int lane,
                                input logic [AW-1:0] init, input int nb,
                                input logic [MW-1:0] a0, input logic [MW-1:0] b0,
                                input logic [MW-1:0] a1, input logic [MW-1:0] b1,
                                input logic [MW-1:0] a2, input logic [MW-1:0] b2,
                                input logic [AW-1:0] exp_w, input logic [AW-1:0] exp_s);
        vec_t v;
        v.mode = mode; v.len = len; v.lane = lane; v.init = init; v.nb = nb;
        v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1; v.a[2] = a2; v.b[2] = b2;
        v.exp_w = exp_w; v.exp_s = exp_s;
        return v;
    endfunction

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        logic [L*AW-1:0] exp_word;

        // mode: [0] 1=MAC 0=MUL, [1] 1=signed
        vecs[0] = mk(2'b01, 8'd3, 0, 32'd0, 3, 8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd1, 32'd27, 32'd27);
        vecs[1] = mk(2'b11, 8'd2, 1, 32'd100, 2, 8'hFD, 8'd4, 8'hFE, 8'hFB, 8'd0, 8'd0, 32'd98, 32'd98);
        vecs[2] = mk(2'b10, 8'd1, 2, 32'd0, 1, 8'h80, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 32'd16384, 32'd16384);
        // 0x7FFFFFF0 + 16129 wraps to 0x80003EF1; clamps to the signed maximum
        vecs[3] = mk(2'b11, 8'd1, 3, 32'h7FFFFFF0, 1, 8'd127, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0,
                     32'h80003EF1, 32'h7FFFFFFF);
        // len 0 behaves as 1; unsigned 0xFFFFFFFF + 65025 wraps / clamps
        vecs[4] = mk(2'b01, 8'd0, 0, 32'hFFFFFFFF, 1, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0,
                     32'h0000FE00, 32'hFFFFFFFF);
        // intermediate sum underflows: clamped acc then +1
        vecs[5] = mk(2'b11, 8'd2, 2, 32'h80000005, 2, 8'h80, 8'd127, 8'd1, 8'd1, 8'd0, 8'd0,
                     32'h7FFFC086, 32'h80000001);
        vecs[6] = mk(2'b00, 8'd5, 3, 32'd77, 1, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 32'd65025, 32'd65025);
        vecs[7] = mk(2'b10, 8'd1, 1, 32'd0, 1, 8'hFF, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 32'hFFFFFFFE, 32'hFFFFFFFE);

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_mode  = '0;
        cfg_len   = '0;
        cfg_init  = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset out_valid", out_valid_w, 1'b0);
        check("reset out_data",  out_data_w,  '0);
        check("reset cfg_ready", cfg_ready_w, 1'b1);
        check("reset in_ready",  in_ready_w,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            do_cfg(vecs[i].mode, vecs[i].len, lane_word(vecs[i].lane, vecs[i].init));
            for (int k = 0; k < vecs[i].nb; k++) begin
                do_beat(lane_op(vecs[i].lane, vecs[i].a[k]), lane_op(vecs[i].lane, vecs[i].b[k]));
            end
            exp_word = lane_word(vecs[i].lane, vecs[i].exp_w);
            check($sformatf("vec%0d out_valid", i), out_valid_w, 1'b1);
            check($sformatf("vec%0d wrap data", i), out_data_w, exp_word);
            exp_word = lane_word(vecs[i].lane, vecs[i].exp_s);
            check($sformatf("vec%0d sat data", i), out_data_s, exp_word);
            tick();
        end

        // Re-arm: two signed len=2 vectors back to back on lane 1, init 100
        do_cfg(2'b11, 8'd2, lane_word(1, 32'd100));
        for (int v = 0; v < 2; v++) begin
            do_beat(lane_op(1, 8'hFD), lane_op(1, 8'd4));
            do_beat(lane_op(1, 8'hFE), lane_op(1, 8'hFB));
            check($sformatf("rearm vector%0d", v), out_data_w, lane_word(1, 32'd98));
        end
        tick();

        // Back-to-back MUL beats: a new result every cycle with no bubble
        do_cfg(2'b00, 8'd0, '0);
        for (int k = 0; k < 4; k++) begin
            do_beat(lane_op(0, MW'(k + 3)), lane_op(0, MW'(k + 5)));
            check($sformatf("mul stream%0d valid", k), out_valid_w, 1'b1);
            check($sformatf("mul stream%0d data", k), out_data_w, lane_word(0, AW'((k + 3) * (k + 5))));
        end
        tick();

        // Back-pressure: result held for 3 cycles, no beat accepted meanwhile
        do_cfg(2'b10, 8'd1, '0);
        out_ready = 1'b0;
        do_beat(lane_op(2, 8'h80), lane_op(2, 8'h80));
        in_a     = lane_op(2, 8'd1);
        in_b     = lane_op(2, 8'd1);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d in_ready", k), in_ready_w, 1'b0);
            check($sformatf("stall%0d out_valid", k), out_valid_w, 1'b1);
            check($sformatf("stall%0d data", k), out_data_w, lane_word(2, 32'd16384));
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("stall release data", out_data_w, lane_word(2, 32'd1));
        tick();

        // Config offered mid-vector: refused until the result is emitted and taken
        do_cfg(2'b01, 8'd2, '0);
        do_beat(lane_op(0, 8'd3), lane_op(0, 8'd3));
        cfg_mode  = 2'b10;
        cfg_len   = 8'd1;
        cfg_init  = '0;
        cfg_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("midvec%0d cfg_ready", k), cfg_ready_w, 1'b0);
            tick();
        end
        out_ready = 1'b0;
        in_a      = lane_op(0, 8'd2);
        in_b      = lane_op(0, 8'd2);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        check("midvec pending cfg_ready", cfg_ready_w, 1'b0);
        check("midvec result", out_data_w, lane_word(0, 32'd13));
        tick();
        out_ready = 1'b1;
        tick();
        in_a     = lane_op(0, 8'hFF);
        in_b     = lane_op(0, 8'hFF);
        in_valid = 1'b1;
        #1;
        check("collision cfg_ready", cfg_ready_w, 1'b1);
        check("collision in_ready", in_ready_w, 1'b0);
        tick();
        cfg_valid = 1'b0;
        tick();
        in_valid = 1'b0;
        check("new cfg signed mul", out_data_w, lane_word(0, 32'd1));
        tick();

        // Asynchronous reset mid-vector
        do_cfg(2'b01, 8'd3, '0);
        do_beat(lane_op(0, 8'd5), lane_op(0, 8'd5));
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", out_valid_w, 1'b0);
        check("midreset out_data",  out_data_w,  '0);
        check("midreset cfg_ready", cfg_ready_w, 1'b1);
        check("midreset in_ready",  in_ready_w,  1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_cfg(2'b01, 8'd1, '0);
        do_beat(lane_op(0, 8'd2), lane_op(0, 8'd2));
        check("post reset result", out_data_w, lane_word(0, 32'd4));
        tick();

        // Randomized phase against the model
        n_results = 0;
        for (int c = 0; c < 3000; c++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_mode  = 2'($urandom);
            cfg_len   = LW'($urandom_range(0, 4));
            for (int l = 0; l < L; l++) begin
                cfg_init[l*AW +: AW] = rand_init();
                in_a[l*MW +: MW]     = rand_op();
                in_b[l*MW +: MW]     = rand_op();
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("random results produced", n_results >= 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
